// File: rtl/sw_cond_pkg.sv
// Shared constants and debounce state encoding for the slide-switch conditioner.
package sw_cond_pkg;
   localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;
   localparam int unsigned DEBOUNCE_CYCLES_HW  = 500000;

   typedef enum logic {
      IDLE     = 1'b0,
      COUNTING = 1'b1
   } db_state_e;
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, debounce counter, clean level,
// registered rise/fall pulses and a sticky change flag.
module sw_debounce_bit
   import sw_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   input  logic ack,
   output logic level,
   output logic rise,
   output logic fall,
   output logic flag
);
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   db_state_e        state_c;
   logic             accept_c;
   logic             level_nxt;
   logic             rise_nxt;
   logic             fall_nxt;
   logic             flag_nxt;

   // The debounce state is implied by whether the synchronised pin disagrees with the level.
   always_comb begin
      state_c = (s2 != level) ? COUNTING : IDLE;
   end

   // Counter advance and acceptance: accept on the edge the count would reach DEBOUNCE_CYCLES.
   always_comb begin
      cnt_nxt  = '0;
      accept_c = 1'b0;
      case (state_c)
         IDLE: begin
            cnt_nxt = '0;
         end
         COUNTING: begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               accept_c = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_nxt = '0;
         end
      endcase
   end

   // Output next values; the flag is set from the registered pulse so a same-cycle ack loses.
   always_comb begin
      level_nxt = accept_c ? s2 : level;
      rise_nxt  = accept_c & s2;
      fall_nxt  = accept_c & ~s2;
      flag_nxt  = rise | fall | (flag & ~ack);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         flag  <= 1'b0;
      end else begin
         s1    <= pin;
         s2    <= s1;
         cnt   <= cnt_nxt;
         level <= level_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
         flag  <= flag_nxt;
      end
   end
endmodule

// File: rtl/sw_input_conditioner.sv
// Slide-switch front end: per-bit synchronise/debounce, edge pulses and
// sticky change flags feeding the LED gate logic.
module sw_input_conditioner
   import sw_cond_pkg::*;
#(
   parameter int unsigned N_SW            = 10,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
   input  logic            MAX10_CLK1_50,
   input  logic            reset,
   input  logic [N_SW-1:0] SW,
   output logic [N_SW-1:0] sw_level,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall,
   output logic [N_SW-1:0] evt_flags,
   output logic            evt_valid,
   input  logic [N_SW-1:0] evt_ack
);
   for (genvar i = 0; i < int'(N_SW); i++) begin : g_bit
      sw_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk  (MAX10_CLK1_50),
         .reset(reset),
         .pin  (SW[i]),
         .ack  (evt_ack[i]),
         .level(sw_level[i]),
         .rise (sw_rise[i]),
         .fall (sw_fall[i]),
         .flag (evt_flags[i])
      );
   end

   assign evt_valid = |evt_flags;
endmodule
